dual_port_regfile: RTL

- Parametrised register file for the single-cycle processor datapath, with DEPTH = 2**ADDR_W entries of WIDTH bits.
- Two write ports and two read ports, all active in the same cycle.
- Read data is registered, so it appears one cycle after the request.
- When both write ports target the same address, a round-robin priority bit picks the winner and alternates between the ports.

---
 rtl/dual_port_regfile.sv | 100 ++++++++++
 1 files changed

// File: rtl/dual_port_regfile.sv
// Two-write / two-read register file with registered reads and round-robin write collision arbitration.
// Optional macro DUAL_PORT_REGFILE_BYPASS_EN forwards same-cycle committed write data to a read of that address.
module dual_port_regfile #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [WIDTH-1:0]  wdata1,
    input  logic              re0,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [WIDTH-1:0]  rdata0,
    output logic              rvalid0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    output logic              rvalid1,
    output logic              wconflict,
    output logic              prio
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             collision;
    logic             commit0;
    logic             commit1;

    logic [WIDTH-1:0] rdata0_p1;
    logic [WIDTH-1:0] rdata1_p1;
    logic             vld0_p1;
    logic             vld1_p1;
    logic             wconflict_p1;
    logic             prio_q;

    // A same-address collision lets only the port named by prio commit.
    assign collision = we0 & we1 & (waddr0 == waddr1);
    assign commit0   = we0 & ~(collision &  prio_q);
    assign commit1   = we1 & ~(collision & ~prio_q);

    function automatic logic [WIDTH-1:0] read_word(input logic [ADDR_W-1:0] a);
`ifdef DUAL_PORT_REGFILE_BYPASS_EN
        if (commit1 && (waddr1 == a))
            return wdata1;
        else if (commit0 && (waddr0 == a))
            return wdata0;
        else
            return mem[a];
`else
        return mem[a];
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (commit0)
                mem[waddr0] <= wdata0;
            if (commit1)
                mem[waddr1] <= wdata1;
        end
    end

    // Stage p1: registered read data, valids and collision status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_p1    <= '0;
            rdata1_p1    <= '0;
            vld0_p1      <= 1'b0;
            vld1_p1      <= 1'b0;
            wconflict_p1 <= 1'b0;
            prio_q       <= 1'b0;
        end else begin
            vld0_p1      <= re0;
            vld1_p1      <= re1;
            wconflict_p1 <= collision;
            prio_q       <= prio_q ^ collision;
            if (re0)
                rdata0_p1 <= read_word(raddr0);
            if (re1)
                rdata1_p1 <= read_word(raddr1);
        end
    end

    assign rdata0    = rdata0_p1;
    assign rdata1    = rdata1_p1;
    assign rvalid0   = vld0_p1;
    assign rvalid1   = vld1_p1;
    assign wconflict = wconflict_p1;
    assign prio      = prio_q;

endmodule
